uart_rx_word: RTL and testbench

//  8N1 UART receiver. Sits next to the SoC UART transmitter and accepts host bytes on the uart_rx pin.

---
 rtl/uart_rx_word_pkg.sv | 34 +++
 rtl/uart_rx_word_if.sv | 12 +
 rtl/uart_rx_byte.sv | 142 ++++++++++++++
 rtl/uart_rx_word.sv | 99 +++++++++
 tb/tb_uart_rx_word.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_word_pkg.sv
// Shared definitions for the UART receive path: FSM encodings, default bit
// timing (also used by the transmitter) and the byte-into-word placement helper.
package uart_rx_word_pkg;

  localparam int DEF_CLKS_PER_BIT = 234;      // 27 MHz / 115200
  localparam int DEF_GAP_TIMEOUT  = 2700000;  // ~100 ms of idle at 27 MHz
  localparam int BYTE_W           = 8;
  localparam int WORD_W           = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Place byte b into slot k of w; slot 0 is the most significant byte so the
  // first byte on the wire ends up in [31:24].
  function automatic logic [WORD_W-1:0] insert_byte(input logic [WORD_W-1:0] w,
                                                    input logic [1:0]        k,
                                                    input logic [BYTE_W-1:0] b);
    logic [WORD_W-1:0] r;
    r = w;
    case (k)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_word_if.sv
// Word handshake between the receiver (master) and the CPU/MMU side (slave).
interface uart_rx_word_if;
  import uart_rx_word_pkg::*;

  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchronizer plus a mid-bit sampling FSM.
// Emits a one-cycle byte_valid for a good stop bit or a one-cycle frame_err
// for a low stop bit; after a framing error it waits for the line to go high.
module uart_rx_byte
  import uart_rx_word_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_W       = BYTE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  output logic [DATA_W-1:0] byte_data,
  output logic              byte_valid,
  output logic              frame_err,
  output logic              rx_start,
  output logic              rx_idle
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  logic              rx_p0;
  logic              rx_s;
  rx_state_t         state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [DATA_W-1:0] byte_data_nxt;
  logic              byte_valid_nxt;
  logic              frame_err_nxt;

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= uart_rx;
      rx_s  <= rx_p0;
    end
  end

  // FSM state, bit timing counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      shreg      <= shreg_nxt;
      byte_data  <= byte_data_nxt;
      byte_valid <= byte_valid_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

  // Next-state logic: sample the start bit at half a bit, then every full bit.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    bit_idx_nxt    = bit_idx;
    shreg_nxt      = shreg;
    byte_data_nxt  = byte_data;
    byte_valid_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nxt = ST_START;
          cnt_nxt   = '0;
        end
      end
      ST_START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          if (!rx_s) begin
            state_nxt   = ST_DATA;
            bit_idx_nxt = '0;
          end else begin
            // Line was only glitching; drop it silently.
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt            = '0;
          shreg_nxt[bit_idx] = rx_s;
          if (bit_idx == IDX_LAST) begin
            state_nxt = ST_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            byte_data_nxt  = shreg;
            byte_valid_nxt = 1'b1;
            state_nxt      = ST_IDLE;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = ST_BREAK;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_BREAK: begin
        // A line held low must return high before a new start is accepted.
        if (rx_s) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign rx_idle  = (state == ST_IDLE);
  assign rx_start = (state == ST_IDLE) && !rx_s;

endmodule

// File: rtl/uart_rx_word.sv
// UART receiver with 32-bit word assembly. Bytes are packed first-byte-in-MSB
// to match the transmitter, a gap timer discards stale partial words, and the
// finished word is offered on a valid/ready port with a sticky overrun flag.
module uart_rx_word
  import uart_rx_word_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int GAP_TIMEOUT  = DEF_GAP_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  output logic              frame_err,
  output logic              overrun,
  uart_rx_word_if.master    word_if
);

  localparam int GAP_W = $clog2(GAP_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);

  logic              rx_start;
  logic              rx_idle;
  logic [1:0]        byte_cnt;
  logic [WORD_W-1:0] word_buf;
  logic [WORD_W-1:0] word_full;
  logic [GAP_W-1:0]  gap_cnt;
  logic              word_done;
  logic              word_take;
  logic              word_load;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_W       (BYTE_W)
  ) u_byte (
    .clk        (clk),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .rx_start   (rx_start),
    .rx_idle    (rx_idle)
  );

  assign word_full = insert_byte(word_buf, byte_cnt, byte_data);
  assign word_done = byte_valid && (byte_cnt == 2'd3);
  assign word_take = word_if.word_valid && word_if.word_ready;
  // A finished word may load if the port is empty or being drained this cycle.
  assign word_load = word_done && (!word_if.word_valid || word_if.word_ready);

  // Byte packing and the idle-gap timer that abandons partial words.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt <= '0;
      word_buf <= '0;
      gap_cnt  <= '0;
    end else begin
      if (frame_err) begin
        byte_cnt <= '0;
        gap_cnt  <= '0;
      end else if (byte_valid) begin
        word_buf <= word_full;
        byte_cnt <= byte_cnt + 2'd1;
        gap_cnt  <= '0;
      end else if (rx_start || byte_cnt == 2'd0) begin
        gap_cnt <= '0;
      end else if (rx_idle) begin
        if (gap_cnt == GAP_LAST) begin
          byte_cnt <= '0;
          gap_cnt  <= '0;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
      end
    end
  end

  // Word handshake: load, hold until accepted, flag words lost to back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_if.word_data  <= '0;
      word_if.word_valid <= 1'b0;
      overrun            <= 1'b0;
    end else begin
      if (word_load) begin
        word_if.word_data  <= word_full;
        word_if.word_valid <= 1'b1;
      end else if (word_take) begin
        word_if.word_valid <= 1'b0;
      end
      if (word_done && !word_load) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_word.sv
// Bench for uart_rx_word at 16 clk/bit with a 1000-clk gap timeout.
module tb_uart_rx_word;
  import uart_rx_word_pkg::*;

  localparam int CPB = 16;
  localparam int GAP = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;
  logic       overrun;

  uart_rx_word_if wif ();

  uart_rx_word #(
    .CLKS_PER_BIT (CPB),
    .GAP_TIMEOUT  (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .word_if    (wif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed events, sampled on the falling edge.
  logic [7:0]  obs_bytes[$];
  logic [31:0] obs_words[$];
  int          ferr_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (byte_valid) obs_bytes.push_back(byte_data);
      if (frame_err) ferr_cnt++;
      if (wif.word_valid && wif.word_ready) obs_words.push_back(wif.word_data);
    end
  end

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         exp_bytes;
    logic [7:0] exp_last;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int hold_low);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      tick(CPB);
    end
    uart_rx = stop_ok;
    tick(CPB);
    if (!stop_ok && hold_low > 0) tick(hold_low);
    uart_rx = 1'b1;
  endtask

  task automatic do_reset();
    uart_rx = 1'b1;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(5);
  endtask

  int bb, wb, fb;
  logic [7:0]  d8;
  bit          ok;
  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_words[$];
  logic [7:0]  pend[$];
  int          exp_ferr;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
    vecs[1] = '{8'h3C, 1'b0, 0, 8'hA5, 1};
    vecs[2] = '{8'h00, 1'b1, 1, 8'h00, 0};
    vecs[3] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
    wif.word_ready = 1'b1;

    // Reset state
    tick(1);
    do_reset();
    chk("reset byte_data", byte_data, 0);
    chk("reset byte_valid", byte_valid, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset overrun", overrun, 0);
    chk("reset word_valid", wif.word_valid, 0);
    chk("reset word_data", wif.word_data, 0);

    // Single-frame table: good bytes and a framing error
    for (int i = 0; i < 4; i++) begin
      bb = obs_bytes.size();
      fb = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].stop_ok, 0);
      tick(20);
      chk($sformatf("vec%0d byte count", i), obs_bytes.size() - bb, vecs[i].exp_bytes);
      chk($sformatf("vec%0d byte_data", i), byte_data, vecs[i].exp_last);
      chk($sformatf("vec%0d frame_err count", i), ferr_cnt - fb, vecs[i].exp_ferr);
      chk($sformatf("vec%0d word_valid", i), wif.word_valid, 0);
    end

    // Glitch on an idle line, then a clean byte
    do_reset();
    bb = obs_bytes.size();
    fb = ferr_cnt;
    uart_rx = 1'b0;
    tick(5);
    uart_rx = 1'b1;
    tick(40);
    chk("glitch byte count", obs_bytes.size() - bb, 0);
    chk("glitch frame_err", ferr_cnt - fb, 0);
    send_frame(8'h5A, 1'b1, 0);
    tick(5);
    chk("after glitch byte count", obs_bytes.size() - bb, 1);
    chk("after glitch byte_data", byte_data, 8'h5A);

    // Four back-to-back bytes form one word
    do_reset();
    wb = obs_words.size();
    send_frame(8'hF9, 1'b1, 0);
    send_frame(8'hB9, 1'b1, 0);
    send_frame(8'h9B, 1'b1, 0);
    send_frame(8'h9F, 1'b1, 0);
    tick(5);
    chk("word count", obs_words.size() - wb, 1);
    if (obs_words.size() > wb) chk("word value", obs_words[wb], 32'hF9B99B9F);
    chk("word_valid after accept", wif.word_valid, 0);

    // Framing error with a held-low line, then a clean word
    do_reset();
    bb = obs_bytes.size();
    wb = obs_words.size();
    fb = ferr_cnt;
    send_frame(8'h3C, 1'b0, 40);
    tick(20);
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 0);
    tick(5);
    chk("break frame_err count", ferr_cnt - fb, 1);
    chk("break byte count", obs_bytes.size() - bb, 4);
    chk("break word count", obs_words.size() - wb, 1);
    if (obs_words.size() > wb) chk("break word value", obs_words[wb], 32'h01020304);

    // Back-pressure: second word is lost and overrun sticks
    do_reset();
    wif.word_ready = 1'b0;
    wb = obs_words.size();
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, 0);
    tick(3);
    chk("bp word_valid", wif.word_valid, 1);
    chk("bp word_data", wif.word_data, 32'h11121314);
    chk("bp overrun early", overrun, 0);
    for (int i = 4; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b1, 0);
    tick(3);
    chk("bp overrun", overrun, 1);
    chk("bp word_data held", wif.word_data, 32'h11121314);
    chk("bp word_valid held", wif.word_valid, 1);
    wif.word_ready = 1'b1;
    tick(2);
    chk("bp word_valid drop", wif.word_valid, 0);
    chk("bp overrun sticky", overrun, 1);
    chk("bp accepted count", obs_words.size() - wb, 1);
    if (obs_words.size() > wb) chk("bp accepted word", obs_words[wb], 32'h11121314);

    // Gap timeout discards a partial word
    do_reset();
    chk("overrun cleared by reset", overrun, 0);
    wb = obs_words.size();
    send_frame(8'h55, 1'b1, 0);
    send_frame(8'h66, 1'b1, 0);
    tick(1200);
    send_frame(8'hAA, 1'b1, 0);
    send_frame(8'hBB, 1'b1, 0);
    send_frame(8'hCC, 1'b1, 0);
    send_frame(8'hDD, 1'b1, 0);
    tick(5);
    chk("gap word count", obs_words.size() - wb, 1);
    if (obs_words.size() > wb) chk("gap word value", obs_words[wb], 32'hAABBCCDD);

    // Reset in the middle of a frame
    fork
      send_frame(8'h77, 1'b1, 0);
      begin
        tick(80);
        reset = 1'b1;
      end
    join
    tick(1);
    chk("midreset byte_data", byte_data, 0);
    chk("midreset word_data", wif.word_data, 0);
    chk("midreset word_valid", wif.word_valid, 0);
    chk("midreset byte_valid", byte_valid, 0);
    reset = 1'b0;
    tick(10);
    bb = obs_bytes.size();
    send_frame(8'h3E, 1'b1, 0);
    tick(5);
    chk("post-reset byte count", obs_bytes.size() - bb, 1);
    chk("post-reset byte_data", byte_data, 8'h3E);

    // Randomized traffic against a byte-list/word-list reference
    do_reset();
    bb = obs_bytes.size();
    wb = obs_words.size();
    fb = ferr_cnt;
    exp_ferr = 0;
    for (int n = 0; n < 24; n++) begin
      d8 = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send_frame(d8, ok, 0);
      if (ok) begin
        exp_bytes.push_back(d8);
        pend.push_back(d8);
        if (pend.size() == 4) begin
          exp_words.push_back({pend[0], pend[1], pend[2], pend[3]});
          pend.delete();
        end
        tick($urandom_range(0, 20));
      end else begin
        exp_ferr++;
        pend.delete();
        tick($urandom_range(6, 20));
      end
    end
    tick(5);
    chk("rand byte count", obs_bytes.size() - bb, exp_bytes.size());
    chk("rand word count", obs_words.size() - wb, exp_words.size());
    chk("rand frame_err count", ferr_cnt - fb, exp_ferr);
    for (int i = 0; i < exp_bytes.size(); i++)
      if (bb + i < obs_bytes.size())
        chk($sformatf("rand byte %0d", i), obs_bytes[bb + i], exp_bytes[i]);
    for (int i = 0; i < exp_words.size(); i++)
      if (wb + i < obs_words.size())
        chk($sformatf("rand word %0d", i), obs_words[wb + i], exp_words[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "time limit reached");
  end

endmodule
